vec_host_issuer: RTL

Host-side initiator for the vector accelerator's command/result interface. It buffers host commands in a small FIFO and issues them one at a time, holding operands stable until the accelerator signals completion. For read commands (op 4'b1000) it captures the result vector, acknowledges it, and presents it to the host on a valid/yumi response port. It sits between the host/testbench and the accelerator top.

---
 rtl/vec_host_issuer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/vec_host_issuer.sv
// Host-side command issuer for the vector accelerator: FIFO-buffered commands, one in flight, read results returned on a valid/yumi port.
// Optional watchdog on the completion wait is built when VEC_HOST_TIMEOUT_EN is defined.
module vec_host_issuer #(
    parameter int unsigned els_p      = 8,
    parameter int unsigned vlen_p     = 8,
    parameter int unsigned vdw_p      = 8,
    parameter int unsigned fifo_els_p = 4,
    parameter int unsigned timeout_p  = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cmd_v_i,
    output logic                        cmd_ready_o,
    input  logic [3:0]                  cmd_op_i,
    input  logic [$clog2(els_p)-1:0]    cmd_addrA_i,
    input  logic [$clog2(els_p)-1:0]    cmd_addrB_i,
    input  logic [$clog2(els_p)-1:0]    cmd_addrD_i,
    input  logic [vdw_p-1:0]            cmd_scalar_i,
    input  logic [vlen_p*vdw_p-1:0]     cmd_data_i,
    output logic [3:0]                  acc_op_o,
    output logic [$clog2(els_p)-1:0]    acc_addrA_o,
    output logic [$clog2(els_p)-1:0]    acc_addrB_o,
    output logic [$clog2(els_p)-1:0]    acc_addrD_o,
    output logic [vdw_p-1:0]            acc_scalar_o,
    output logic [vlen_p*vdw_p-1:0]     acc_w_data_o,
    output logic                        acc_v_o,
    input  logic                        acc_ready_i,
    input  logic                        acc_done_i,
    input  logic [vlen_p*vdw_p-1:0]     acc_r_data_i,
    output logic                        acc_yumi_o,
    output logic                        resp_v_o,
    output logic [vlen_p*vdw_p-1:0]     resp_data_o,
    input  logic                        resp_yumi_i,
    output logic                        busy_o,
    output logic                        error_o
);

    localparam int unsigned A_W   = $clog2(els_p);
    localparam int unsigned D_W   = vlen_p * vdw_p;
    localparam int unsigned P_W   = $clog2(fifo_els_p);
    localparam int unsigned PTR_W = P_W + 1;
    localparam int unsigned E_W   = 4 + 3 * A_W + vdw_p + D_W;

    localparam logic [3:0] OP_READ = 4'b1000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_n;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [E_W-1:0]   r_fifo [fifo_els_p];
    logic [E_W-1:0]   w_entry;
    logic [E_W-1:0]   w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic             w_ld_resp;
    logic             w_wait_entry;
    logic             w_abort;
    logic             w_timeout;

    logic [3:0]       r_op;
    logic [A_W-1:0]   r_addr_a;
    logic [A_W-1:0]   r_addr_b;
    logic [A_W-1:0]   r_addr_d;
    logic [vdw_p-1:0] r_scalar;
    logic [D_W-1:0]   r_wdata;
    logic [D_W-1:0]   r_resp_data;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[P_W-1:0] == r_rptr[P_W-1:0]) && (r_wptr[P_W] != r_rptr[P_W]);
    assign w_enq   = cmd_v_i & ~w_full;
    assign w_entry = {cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i, cmd_data_i};
    assign w_head  = r_fifo[r_rptr[P_W-1:0]];

    // Command storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo[r_wptr[P_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_deq        = 1'b0;
        w_ld_resp    = 1'b0;
        w_wait_entry = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_deq     = 1'b1;
                    w_state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (acc_ready_i) begin
                    w_wait_entry = 1'b1;
                    w_state_n    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (acc_done_i) begin
                    if (r_op == OP_READ) begin
                        w_ld_resp = 1'b1;
                        w_state_n = S_RESP;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_abort   = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            S_RESP: begin
                if (resp_yumi_i) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Operands load only at dequeue so the accelerator sees them stable for the whole operation.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op     <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_d <= '0;
            r_scalar <= '0;
            r_wdata  <= '0;
        end else if (w_deq) begin
            {r_op, r_addr_a, r_addr_b, r_addr_d, r_scalar, r_wdata} <= w_head;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_resp_data <= '0;
        end else if (w_ld_resp) begin
            r_resp_data <= acc_r_data_i;
        end
    end

`ifdef VEC_HOST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(timeout_p + 1);

    logic [TO_W-1:0] r_wd_cnt;
    logic            r_error;

    assign w_timeout = (r_wd_cnt == TO_W'(timeout_p - 1));

    // Counter restarts on each accepted issue; the error flag is sticky until reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_wait_entry) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd_cnt <= r_wd_cnt + TO_W'(1);
            end
            if (w_abort) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error_o = r_error;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign error_o      = 1'b0;
    assign w_unused_cfg = ^{w_abort, 32'(timeout_p)};
`endif

    assign cmd_ready_o  = ~w_full;
    assign acc_v_o      = (r_state == S_ISSUE);
    assign acc_yumi_o   = w_ld_resp;
    assign resp_v_o     = (r_state == S_RESP);
    assign busy_o       = (r_state != S_IDLE) | ~w_empty;
    assign acc_op_o     = r_op;
    assign acc_addrA_o  = r_addr_a;
    assign acc_addrB_o  = r_addr_b;
    assign acc_addrD_o  = r_addr_d;
    assign acc_scalar_o = r_scalar;
    assign acc_w_data_o = r_wdata;
    assign resp_data_o  = r_resp_data;

endmodule
